// File: rtl/ucode_seq.sv
// -----------------------------------------------------------------------------
// ucode_seq_pkg / ucode_seq
//
// Micro-code sequencer stage (UC), sitting directly behind the decode uop
// queue (DE1) and in front of rename (RN0). Each decoded uop is either passed
// through unchanged or expanded into a short micro-uop sequence taken from an
// internal expansion table. The UC1 output is fully registered.
//
// Handshakes (valid/ready):
//   - DE1 -> UC: a uop transfers on a cycle where valid_de1 & ucode_ready_uc0.
//     ucode_ready_uc0 never depends on valid_de1, and decode only raises
//     valid_de1 while ready is high, so every valid_de1 is a transfer.
//   - UC1 -> RN0: a uop transfers on a cycle where valid_uc1 & rename_ready_rn0
//     & ~nuke_rb1.valid. While valid_uc1 is high and rename is not ready, every
//     UC1 output holds its value.
//
// Ports:
//   clk               core clock
//   reset             asynchronous, active-low reset
//   nuke_rb1          retire-stage flush (only .valid is used)
//   valid_de1         uop presented by decode this cycle
//   uinstr_de1        decoded uop
//   ucode_ready_uc0   sequencer can accept a uop this cycle
//   rename_ready_rn0  rename consumes the UC1 uop this cycle
//   valid_uc1         UC1 output valid
//   uinstr_uc1        UC1 uop
//   uc_idx_uc1        index of the uop within its sequence (0 for pass-through)
//   eom_uc1           last uop of its macro-uop (1 for pass-through)
//   state_dbg         current sequencer state, for observation only
//
// Optional build macro UCODE_PERF_EN adds three 32-bit saturating counters:
//   perf_macro_cnt    accepted decode uops
//   perf_uop_cnt      uops consumed by rename
//   perf_stall_cnt    cycles with valid_uc1 held by rename backpressure
// -----------------------------------------------------------------------------

package ucode_seq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  simid;
        logic [7:0]  uop;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
    } t_uinstr;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } t_nuke_pkt;

    typedef enum logic {
        UC_IDLE = 1'b0,
        UC_SEQ  = 1'b1
    } t_uc_state;

endpackage

module ucode_seq
    import ucode_seq_pkg::*;
#(
    parameter int  MAX_SEQ = 4,
    localparam int IDX_W   = $clog2(MAX_SEQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  t_nuke_pkt        nuke_rb1,
    input  logic             valid_de1,
    input  t_uinstr          uinstr_de1,
    output logic             ucode_ready_uc0,
    input  logic             rename_ready_rn0,
    output logic             valid_uc1,
    output t_uinstr          uinstr_uc1,
    output logic [IDX_W-1:0] uc_idx_uc1,
    output logic             eom_uc1,
    output t_uc_state        state_dbg
`ifdef UCODE_PERF_EN
    ,
    output logic [31:0]      perf_macro_cnt,
    output logic [31:0]      perf_uop_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    // Scratch register used to chain intermediate results inside a sequence.
    localparam logic [4:0] TMP_REG = 5'd31;

    // Expansion table: number of micro-uops for a macro opcode.
    function automatic logic [7:0] f_ucode_len(input logic [7:0] uop);
        case (uop)
            8'hC2:   return 8'd2;
            8'hC3:   return 8'd3;
            8'hC4:   return 8'd4;
            default: return 8'd1;
        endcase
    endfunction

    // idx-th micro-uop of an expanded macro. pc and simid come from the macro;
    // the opcode is {macro opcode low nibble, step} and operands form a chain:
    // first step reads the macro sources, middle steps accumulate in TMP_REG,
    // the last step writes the macro destination.
    function automatic t_uinstr f_ucode_step(input t_uinstr m, input logic [IDX_W-1:0] idx);
        t_uinstr          s;
        logic [IDX_W-1:0] last;
        logic [3:0]       idx4;
        s    = m;
        last = IDX_W'(f_ucode_len(m.uop) - 8'd1);
        idx4 = 4'(idx);
        s.uop  = {m.uop[3:0], idx4};
        s.src1 = (idx == '0)   ? m.src1 : TMP_REG;
        s.src2 = (idx == last) ? 5'd0   : m.src2;
        s.dst  = (idx == last) ? m.dst  : TMP_REG;
        return s;
    endfunction

    t_uc_state        state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx_q;
    t_uinstr          macro_q;

    logic             out_free;
    logic             accept;
    logic [7:0]       de_len;
    t_uinstr          de_step0;
    t_uinstr          seq_step;

    // Only the valid bit of the nuke packet matters here.
    logic [31:0]      unused_nuke_pc;
    assign unused_nuke_pc = nuke_rb1.pc;

    assign out_free        = ~valid_uc1 | rename_ready_rn0;
    assign ucode_ready_uc0 = reset & ~nuke_rb1.valid & (state == UC_IDLE) & out_free;
    assign accept          = valid_de1 & ucode_ready_uc0;
    assign de_len          = f_ucode_len(uinstr_de1.uop);
    assign de_step0        = f_ucode_step(uinstr_de1, '0);
    assign seq_step        = f_ucode_step(macro_q, idx);
    assign state_dbg       = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= UC_IDLE;
            idx        <= '0;
            last_idx_q <= '0;
            macro_q    <= '0;
            valid_uc1  <= 1'b0;
            uinstr_uc1 <= '0;
            uc_idx_uc1 <= '0;
            eom_uc1    <= 1'b0;
        end else if (nuke_rb1.valid) begin
            // Flush wins over a same-cycle rename consume.
            valid_uc1 <= 1'b0;
            state     <= UC_IDLE;
            idx       <= '0;
        end else begin
            case (state)
                UC_IDLE: begin
                    if (out_free) begin
                        valid_uc1 <= accept;
                        if (accept) begin
                            uc_idx_uc1 <= '0;
                            if (de_len == 8'd1) begin
                                // Pass-through: emitted bit-identical.
                                uinstr_uc1 <= uinstr_de1;
                                eom_uc1    <= 1'b1;
                            end else begin
                                uinstr_uc1 <= de_step0;
                                eom_uc1    <= 1'b0;
                                macro_q    <= uinstr_de1;
                                last_idx_q <= IDX_W'(de_len - 8'd1);
                                idx        <= IDX_W'(1);
                                state      <= UC_SEQ;
                            end
                        end
                    end
                end
                UC_SEQ: begin
                    // Under backpressure idx and state simply hold.
                    if (out_free) begin
                        valid_uc1  <= 1'b1;
                        uinstr_uc1 <= seq_step;
                        uc_idx_uc1 <= idx;
                        if (idx == last_idx_q) begin
                            eom_uc1 <= 1'b1;
                            idx     <= '0;
                            state   <= UC_IDLE;
                        end else begin
                            eom_uc1 <= 1'b0;
                            idx     <= idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef UCODE_PERF_EN
    logic uop_consumed;
    logic stall_cycle;
    assign uop_consumed = valid_uc1 & rename_ready_rn0 & ~nuke_rb1.valid;
    assign stall_cycle  = valid_uc1 & ~rename_ready_rn0;

    // Counters saturate and survive nukes; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_macro_cnt <= '0;
            perf_uop_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && (perf_macro_cnt != 32'hFFFF_FFFF))
                perf_macro_cnt <= perf_macro_cnt + 32'd1;
            if (uop_consumed && (perf_uop_cnt != 32'hFFFF_FFFF))
                perf_uop_cnt <= perf_uop_cnt + 32'd1;
            if (stall_cycle && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    // Decode must never present a uop while the sequencer is not ready.
    a_valid_needs_ready: assert property (
        @(posedge clk) disable iff (!reset) valid_de1 |-> ucode_ready_uc0);

    // Every opcode must expand to no more than MAX_SEQ micro-uops.
    a_len_in_range: assert property (
        @(posedge clk) disable iff (!reset)
        valid_de1 |-> (f_ucode_len(uinstr_de1.uop) <= 8'(MAX_SEQ)));

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;
  import ucode_seq_pkg::*;

  localparam int MAX_SEQ = 4;
  localparam int IDX_W   = $clog2(MAX_SEQ);
  localparam int EXP_W   = $bits(t_uinstr) + IDX_W + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- dut signals
  t_nuke_pkt        nuke_rb1;
  logic             valid_de1;
  t_uinstr          uinstr_de1;
  logic             ucode_ready_uc0;
  logic             rename_ready_rn0;
  logic             valid_uc1;
  t_uinstr          uinstr_uc1;
  logic [IDX_W-1:0] uc_idx_uc1;
  logic             eom_uc1;
  t_uc_state        state_dbg;
`ifdef UCODE_PERF_EN
  logic [31:0]      perf_macro_cnt;
  logic [31:0]      perf_uop_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  ucode_seq #(.MAX_SEQ(MAX_SEQ)) dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke_rb1),
    .valid_de1        (valid_de1),
    .uinstr_de1       (uinstr_de1),
    .ucode_ready_uc0  (ucode_ready_uc0),
    .rename_ready_rn0 (rename_ready_rn0),
    .valid_uc1        (valid_uc1),
    .uinstr_uc1       (uinstr_uc1),
    .uc_idx_uc1       (uc_idx_uc1),
    .eom_uc1          (eom_uc1),
    .state_dbg        (state_dbg)
`ifdef UCODE_PERF_EN
    ,
    .perf_macro_cnt   (perf_macro_cnt),
    .perf_uop_cnt     (perf_uop_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int model_len(input logic [7:0] uop);
    if (uop == 8'hC2) return 2;
    if (uop == 8'hC3) return 3;
    if (uop == 8'hC4) return 4;
    return 1;
  endfunction

  function automatic logic [EXP_W-1:0] model_uop(input t_uinstr m, input int k, input int len);
    t_uinstr s;
    logic    last;
    s    = m;
    last = (k == len - 1);
    if (len > 1) begin
      s.uop  = {m.uop[3:0], 4'(k)};
      s.src1 = (k == 0) ? m.src1 : 5'd31;
      s.src2 = last ? 5'd0 : m.src2;
      s.dst  = last ? m.dst : 5'd31;
    end
    return {s, IDX_W'(k), last};
  endfunction

  function automatic t_uinstr rand_uinstr(input logic [7:0] uop);
    t_uinstr u;
    u.pc    = $urandom;
    u.simid = 4'($urandom_range(0, 15));
    u.uop   = uop;
    u.src1  = 5'($urandom_range(0, 31));
    u.src2  = 5'($urandom_range(0, 31));
    u.dst   = 5'($urandom_range(0, 31));
    return u;
  endfunction

  function automatic logic [7:0] rand_plain_op();
    return 8'($urandom_range(0, 191));
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [EXP_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (reset) begin
      if (nuke_rb1.valid) begin
        exp_q.delete();
      end else if (valid_uc1) begin
        if (exp_q.size() == 0)
          check("sb_unexpected_uop", 1, 0);
        else if (rename_ready_rn0)
          check("sb_uop", {uinstr_uc1, uc_idx_uc1, eom_uc1}, exp_q.pop_front());
        else
          check("sb_stall_hold", {uinstr_uc1, uc_idx_uc1, eom_uc1}, exp_q[0]);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // One clock cycle: rename/nuke are set just after the rising edge, a uop is
  // offered only if the sequencer is ready, and the task returns mid-cycle
  // so the caller can look at the registers loaded on that rising edge.
  task automatic drive_cycle(input logic v, input t_uinstr u, input logic rr,
                             input logic nk, output logic acc);
    int len;
    @(posedge clk);
    #1;
    rename_ready_rn0 = rr;
    nuke_rb1.valid   = nk;
    valid_de1        = 1'b0;
    acc              = 1'b0;
    #1;
    if (v && ucode_ready_uc0) begin
      valid_de1  = 1'b1;
      uinstr_de1 = u;
      acc        = 1'b1;
      len        = model_len(u.uop);
      for (int k = 0; k < len; k++) exp_q.push_back(model_uop(u, k, len));
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic    acc;
    t_uinstr u;
    t_uinstr p;
    t_uinstr pt[8];

    reset            = 1'b0;
    valid_de1        = 1'b0;
    uinstr_de1       = '0;
    rename_ready_rn0 = 1'b1;
    nuke_rb1         = '0;

    // Reset held for 3 cycles, rename ready so only reset can hold ready low.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_valid", valid_uc1, 0);
      check("rst_ready", ucode_ready_uc0, 0);
      check("rst_outputs", {uinstr_uc1, uc_idx_uc1, eom_uc1}, 0);
      check("rst_state", state_dbg, UC_IDLE);
`ifdef UCODE_PERF_EN
      check("rst_perf", {perf_macro_cnt, perf_uop_cnt}, 0);
      check("rst_perf_stall", perf_stall_cnt, 0);
`endif
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_release_ready", ucode_ready_uc0, 1);

`ifdef UCODE_PERF_EN
    // Two plain uops, one 3-uop macro, one stall cycle.
    drive_cycle(1, rand_uinstr(rand_plain_op()), 1, 0, acc);
    check("perf_acc_a", acc, 1);
    drive_cycle(1, rand_uinstr(rand_plain_op()), 1, 0, acc);
    check("perf_acc_b", acc, 1);
    drive_cycle(1, rand_uinstr(8'hC3), 1, 0, acc);
    check("perf_acc_c", acc, 1);
    drive_cycle(0, '0, 0, 0, acc);
    repeat (4) drive_cycle(0, '0, 1, 0, acc);
    check("perf_macro_cnt", perf_macro_cnt, 3);
    check("perf_uop_cnt", perf_uop_cnt, 5);
    check("perf_stall_cnt", perf_stall_cnt, 1);
`endif

    // Pass-through stream: 8 plain uops back to back.
    for (int i = 0; i < 8; i++) pt[i] = rand_uinstr(rand_plain_op());
    for (int i = 0; i < 10; i++) begin
      drive_cycle(i < 8, pt[(i < 8) ? i : 0], 1, 0, acc);
      if (i < 8) check("pt_accept", acc, 1);
      check("pt_valid", valid_uc1, (i >= 1 && i <= 8));
      check("pt_ready", ucode_ready_uc0, 1);
      if (i >= 1 && i <= 8) begin
        check("pt_data", uinstr_uc1, pt[i - 1]);
        check("pt_idx", uc_idx_uc1, 0);
        check("pt_eom", eom_uc1, 1);
      end
    end

    // Expansion of a 3-uop macro at pc 0x100, then a plain uop back to back.
    u      = rand_uinstr(8'hC3);
    u.pc   = 32'h100;
    p      = rand_uinstr(rand_plain_op());
    drive_cycle(1, u, 1, 0, acc);
    check("exp_accept", acc, 1);
    for (int j = 1; j <= 5; j++) begin
      drive_cycle(j == 3, p, 1, 0, acc);
      if (j == 3) check("exp_b2b_accept", acc, 1);
      check("exp_valid", valid_uc1, j <= 4);
      check("exp_ready", ucode_ready_uc0, j >= 3);
      if (j <= 3) begin
        check("exp_idx", uc_idx_uc1, j - 1);
        check("exp_eom", eom_uc1, j == 3);
        check("exp_pc", uinstr_uc1.pc, 32'h100);
      end
      if (j == 4) begin
        check("exp_b2b_data", uinstr_uc1, p);
        check("exp_b2b_idx", uc_idx_uc1, 0);
        check("exp_b2b_eom", eom_uc1, 1);
      end
    end

    // Backpressure: rename not ready on cycles 2..4 of a 3-uop sequence.
    u = rand_uinstr(8'hC3);
    drive_cycle(1, u, 1, 0, acc);
    check("bp_accept", acc, 1);
    for (int j = 1; j <= 7; j++) begin
      drive_cycle(0, '0, !(j >= 2 && j <= 4), 0, acc);
      check("bp_valid", valid_uc1, j <= 6);
      check("bp_ready", ucode_ready_uc0, j >= 6);
      if (j <= 6) begin
        check("bp_idx", uc_idx_uc1, (j == 1) ? 0 : ((j <= 5) ? 1 : 2));
        check("bp_eom", eom_uc1, j == 6);
      end
    end

    // Nuke while idx 1 of a 4-uop sequence sits in UC1 and rename is ready.
    u = rand_uinstr(8'hC4);
    p = rand_uinstr(rand_plain_op());
    drive_cycle(1, u, 1, 0, acc);
    check("nk_accept", acc, 1);
    drive_cycle(0, '0, 1, 0, acc);
    check("nk_idx0", uc_idx_uc1, 0);
    drive_cycle(0, '0, 1, 1, acc);
    check("nk_idx1_valid", valid_uc1, 1);
    check("nk_idx1", uc_idx_uc1, 1);
    check("nk_ready_low", ucode_ready_uc0, 0);
    drive_cycle(1, p, 1, 0, acc);
    check("nk_after_accept", acc, 1);
    check("nk_after_valid", valid_uc1, 0);
    check("nk_after_state", state_dbg, UC_IDLE);
    drive_cycle(0, '0, 1, 0, acc);
    check("nk_new_valid", valid_uc1, 1);
    check("nk_new_idx", uc_idx_uc1, 0);
    check("nk_new_eom", eom_uc1, 1);
    check("nk_new_data", uinstr_uc1, p);

    // Random traffic: mixed lengths, random backpressure, occasional nuke.
    for (int c = 0; c < 400; c++) begin
      int sel;
      sel = $urandom_range(0, 3);
      u = rand_uinstr((sel == 0) ? 8'hC2 : (sel == 1) ? 8'hC3 :
                      (sel == 2) ? 8'hC4 : rand_plain_op());
      drive_cycle($urandom_range(0, 1) == 1, u, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0, acc);
    end

    // Drain.
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() != 0) drive_cycle(0, '0, 1, 0, acc);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    drive_cycle(0, '0, 1, 0, acc);
    check("drain_valid", valid_uc1, 0);
    check("drain_state", state_dbg, UC_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
Name: ucode_seq

Overview:
- Micro-code sequencer stage (UC) directly downstream of decode.
- Accepts one decoded uop per cycle from the decode uop queue (DE1), then emits it unchanged or expands it into a multi-uop sequence from an internal ROM.
- Drives a registered UC1 output with a valid/ready handshake toward rename (RN0).
- Flushed by the retire-stage nuke.

Parameters:
- MAX_SEQ, 4: maximum micro-uops per expanded macro-uop; must be ≥2.
- IDX_W, $clog2(MAX_SEQ): width of the sequence index; derived, do not override.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- nuke_rb1  in  t_nuke_pkt  pipeline flush; only .valid is used.
- valid_de1  in  1  uop popped from the decode queue this cycle.
- uinstr_de1  in  t_uinstr  decoded uop.
- ucode_ready_uc0  out  1  sequencer can accept a uop this cycle.
- rename_ready_rn0  in  1  rename consumes the UC1 uop this cycle.
- valid_uc1  out  1  UC1 output valid.
- uinstr_uc1  out  t_uinstr  output uop.
- uc_idx_uc1  out  IDX_W  index of this uop within its sequence (0 for pass-through).
- eom_uc1  out  1  last uop of its macro-uop (1 for pass-through).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, idx=0.
  - valid_uc1=0, uinstr_uc1='0, uc_idx_uc1=0, eom_uc1=0.
  - ucode_ready_uc0=0 while reset is asserted.
- Expansion table:
  - Internal function f_ucode_len(uop) returns 1..MAX_SEQ.
  - f_ucode_step(uinstr, idx) returns the idx-th micro-uop. pc and SIMID are copied from the macro-uop; the uop field and operands come from the table.
  - len==1 means pass-through; uinstr is emitted bit-identical.
- Output register (UC1):
  - out_free = ~valid_uc1 | rename_ready_rn0.
  - The register loads only when out_free. While valid_uc1 & ~rename_ready_rn0, all UC1 outputs hold stable.
- Ready:
  - ucode_ready_uc0 = reset & ~nuke_rb1.valid & (state==IDLE) & out_free.
  - Purely a function of state, the output register, rename_ready_rn0 and nuke; never of valid_de1.
  - Decode asserts valid_de1 only when ready=1, so every valid_de1 is accepted. valid_de1 while ready=0 is an assertion failure.
- FSM:
  - IDLE:
    - On valid_de1, load UC1 next cycle with step 0 (latency 1).
    - If len==1: eom=1, stay in IDLE.
    - Else: latch the macro uinstr, set idx=1, go to SEQ.
  - SEQ:
    - Each cycle with out_free, load step idx, then idx++.
    - When idx==len-1: eom=1, go to IDLE.
    - If ~out_free: hold idx and state.
  - Back-to-back: a sequence's last uop loads in cycle N. ready rises in N+1, so the next macro-uop is accepted in N+1 and appears in N+2. A pass-through stream sustains 1 uop/cycle with rename always ready.
- Nuke (nuke_rb1.valid=1, synchronous):
  - Next cycle: valid_uc1=0, state=IDLE, idx=0.
  - The UC1 uop is discarded even if rename_ready_rn0 was 1 in the same cycle. Rename treats nuke as higher priority.
  - ready=0 during the nuke cycle; normal operation resumes the cycle after.
- Width rule: idx wraps never. len>MAX_SEQ is an assertion failure.
- Simultaneous stall + last uop: eom stays held with the uop until consumed.

Optional Feature:
- UCODE_PERF_EN defined:
  - Adds outputs perf_macro_cnt, perf_uop_cnt and perf_stall_cnt, each 32-bit saturating at 32'hFFFF_FFFF, reset to 0.
  - perf_macro_cnt increments on each accepted valid_de1.
  - perf_uop_cnt increments on each uop consumed by rename.
  - perf_stall_cnt increments on cycles with valid_uc1 & ~rename_ready_rn0.
  - Counters are not cleared by nuke.
- UCODE_PERF_EN undefined: these ports and counters do not exist; functionality is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with valid_de1 forced at 0 -> valid_uc1=0, ready=0. After release, ready=1 next cycle.
- Pass-through stream: 8 len-1 uops on consecutive cycles, rename always ready -> 8 consecutive valid_uc1 cycles starting one cycle after the first input, each with eom=1 and idx=0, uinstr bit-identical to input.
- Expansion: one len-3 uop with pc=0x100 -> UC1 shows idx 0,1,2 on 3 consecutive cycles, pc=0x100 on all three, eom only on idx 2. ready=0 for exactly 2 cycles.
- Backpressure: len-3 uop with rename_ready_rn0=0 for cycles 2–4 of the sequence -> UC1 outputs are stable over the stall, no uop is lost or duplicated, and resume emits idx 1 then 2.
- Nuke mid-sequence: nuke_rb1.valid=1 while idx=1 is in UC1 and rename_ready=1 -> next cycle valid_uc1=0 and state=IDLE. A new len-1 uop accepted after the nuke appears with idx=0.
- UCODE_PERF_EN: 2 len-1 uops plus 1 len-3 uop with one stall cycle -> perf_macro_cnt=3, perf_uop_cnt=5, perf_stall_cnt=1.
